player_controller: RTL

Sequencer for the player-physics datapath. Turns the per-frame `frame_tick` into the two-phase `game_tick` strobe pair (velocity phase, then position phase), converts raw button levels into a one-shot `jump_pulse` and a held `button_down`, and runs the player state machine (idle, run, jump, duck, dead). Sits between the input synchronisers and collision logic on one side and the player-physics block on the other; its `player_state` also feeds sprite selection.

---
 rtl/player_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/player_controller.sv
// Player sequencer: splits frame ticks into velocity/position strobes, edge-detects
// the jump button and runs the idle/run/jump/duck/dead state machine.
module player_controller #(
  parameter int unsigned PHYS_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       collision,
  input  logic       jump_done,
  output logic [1:0] game_tick,
  output logic       jump_pulse,
  output logic       button_down,
  output logic       phys_reset,
  output logic [2:0] player_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    JUMP = 3'd2,
    DUCK = 3'd3,
    DEAD = 3'd4
  } state_e;

  localparam logic [3:0] DIV_LAST = 4'(PHYS_DIV - 1);

  state_e     state_q, state_d;
  logic [3:0] div_q, div_d;
  logic [1:0] tick_q, tick_d;
  logic       jump_req_q, jump_req_d;
  logic       btn_up_q, btn_up_d;
  logic       jump_pulse_q, jump_pulse_d;
  logic       button_down_q, button_down_d;
  logic       phys_reset_q, phys_reset_d;
  logic       rise, alive, due, start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      tick_q        <= '0;
      jump_req_q    <= 1'b0;
      btn_up_q      <= 1'b0;
      jump_pulse_q  <= 1'b0;
      button_down_q <= 1'b0;
      phys_reset_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      tick_q        <= tick_d;
      jump_req_q    <= jump_req_d;
      btn_up_q      <= btn_up_d;
      jump_pulse_q  <= jump_pulse_d;
      button_down_q <= button_down_d;
      phys_reset_q  <= phys_reset_d;
    end
  end

  always_comb begin
    rise  = btn_up & ~btn_up_q;
    alive = (state_q == RUN) || (state_q == JUMP) || (state_q == DUCK);
    due   = frame_tick && (div_q == DIV_LAST);
    // a due update is dropped while a T0/T1 pair is still in flight
    start = due && (tick_q == 2'b00);

    state_d       = state_q;
    div_d         = div_q;
    tick_d        = {tick_q[0], 1'b0};
    jump_req_d    = jump_req_q;
    btn_up_d      = btn_up;
    jump_pulse_d  = 1'b0;
    button_down_d = button_down_q & tick_q[0];
    phys_reset_d  = 1'b0;

    if (!alive) begin
      tick_d        = 2'b00;
      jump_req_d    = 1'b0;
      button_down_d = 1'b0;
      if (rise) begin
        state_d      = RUN;
        phys_reset_d = 1'b1;
        div_d        = '0;
      end
    end else if (collision) begin
      state_d       = DEAD;
      tick_d        = 2'b00;
      jump_req_d    = 1'b0;
      button_down_d = 1'b0;
    end else begin
      if (frame_tick) div_d = due ? 4'd0 : div_q + 4'd1;
      jump_req_d = jump_req_q | rise;
      // landing is judged in T1 using the duck request held since S
      if (tick_q[1] && state_q == JUMP && jump_done)
        state_d = button_down_q ? DUCK : RUN;
      if (start) begin
        tick_d        = 2'b01;
        button_down_d = btn_down;
        jump_req_d    = rise;
        unique case (state_q)
          RUN: begin
            if (btn_down) state_d = DUCK;
            else if (jump_req_q) begin
              state_d      = JUMP;
              jump_pulse_d = 1'b1;
            end
          end
          DUCK:    if (!btn_down) state_d = RUN;
          default: ;
        endcase
      end
    end
  end

  assign game_tick    = tick_q;
  assign jump_pulse   = jump_pulse_q;
  assign button_down  = button_down_q;
  assign phys_reset   = phys_reset_q;
  assign player_state = state_q;

endmodule
